// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that feeds bytes from two requesters into one UART transmitter.
// It keeps one frame in flight, counts completed frames and flags a missed tx_done.
module uart_tx_scheduler #(
    parameter int GAP_CYCLES     = 868,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic [1:0]  grant,
    output logic [15:0] frame_cnt,
    output logic        err_timeout
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t         state_r;
    logic           last_r;
    logic           tx_start_r;
    logic [7:0]     tx_data_r;
    logic [1:0]     grant_r;
    logic [15:0]    frame_cnt_r;
    logic           err_timeout_r;
    logic [TW-1:0]  wait_cnt_r;
    logic [GW-1:0]  gap_cnt_r;
    logic           win0_s;
    logic           win1_s;

    // Winner selection; last_r=1 means requester 1 was served last, so 0 takes a tie
    always_comb begin
        win0_s = 1'b0;
        win1_s = 1'b0;
        if (rst_n && (state_r == IDLE) && !tx_busy) begin
            win1_s = req1_valid && (!req0_valid || !last_r);
            win0_s = req0_valid && !win1_s;
        end else begin
            win0_s = 1'b0;
            win1_s = 1'b0;
        end
    end

    assign req0_ready  = win0_s;
    assign req1_ready  = win1_s;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign grant       = grant_r;
    assign frame_cnt   = frame_cnt_r;
    assign err_timeout = err_timeout_r;

    // Scheduler FSM; wait_cnt_r counts cycles since tx_start, so the timeout lands TIMEOUT_CYCLES after it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            last_r        <= 1'b1;
            tx_start_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            grant_r       <= 2'b00;
            frame_cnt_r   <= 16'h0000;
            err_timeout_r <= 1'b0;
            wait_cnt_r    <= TW'(0);
            gap_cnt_r     <= GW'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    if (win0_s || win1_s) begin
                        tx_data_r  <= win1_s ? req1_data : req0_data;
                        grant_r    <= {win1_s, win0_s};
                        last_r     <= win1_s;
                        tx_start_r <= 1'b1;
                        wait_cnt_r <= TW'(0);
                        state_r    <= START;
                    end else begin
                        tx_start_r <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                START: begin
                    tx_start_r <= 1'b0;
                    wait_cnt_r <= wait_cnt_r + TW'(1);
                    state_r    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done || (wait_cnt_r >= TO_LAST)) begin
                        // tx_done takes precedence over a coincident timeout
                        if (tx_done) begin
                            frame_cnt_r <= frame_cnt_r + 16'd1;
                        end else begin
                            err_timeout_r <= 1'b1;
                        end
                        gap_cnt_r <= GW'(0);
                        if (GAP_CYCLES == 0) begin
                            grant_r <= 2'b00;
                            state_r <= IDLE;
                        end else begin
                            state_r <= GAP;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt_r == GAP_LAST) begin
                        grant_r <= 2'b00;
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    grant_r    <= 2'b00;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed, table-driven bench for uart_tx_scheduler with a stub transmitter.
module tb_uart_tx_scheduler;

    localparam int GAP = 4;
    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy, tx_done;
    logic [1:0]  grant;
    logic [15:0] frame_cnt;
    logic        err_timeout;

    logic        model_busy, hold_busy, model_kill;
    int          done_delay;
    int          tcnt;
    logic        active;
    int          n_cmp = 0;
    int          n_fail = 0;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       rdy0;
        logic       rdy1;
        logic [7:0] data;
        logic [1:0] gnt;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] order_exp[4];

    assign tx_busy = model_busy | hold_busy;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_data(req1_data),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .grant(grant), .frame_cnt(frame_cnt), .err_timeout(err_timeout)
    );

    // Transmitter stub: tx_done in the cycle done_delay cycles after tx_start (0 = never)
    initial begin
        model_busy = 1'b0;
        tx_done    = 1'b0;
        active     = 1'b0;
        tcnt       = 0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n || model_kill) begin
                active     = 1'b0;
                model_busy = 1'b0;
            end else if (active) begin
                tcnt++;
                if (done_delay != 0 && tcnt == done_delay) begin
                    tx_done    = 1'b1;
                    active     = 1'b0;
                    model_busy = 1'b0;
                end
            end else if (tx_start) begin
                active     = 1'b1;
                model_busy = 1'b1;
                tcnt       = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int k = 0;
        while (grant !== 2'b00 && k < limit) begin
            tick();
            k++;
        end
        chk(name, 32'(grant), 32'(2'b00));
    endtask

    task automatic wait_start(input string name, input int limit);
        int k = 0;
        tick();
        while (tx_start !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        chk(name, 32'(tx_start), 32'(1'b1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy0"}, 32'(req0_ready), 32'(1'b0));
        chk({tag, "_rdy1"}, 32'(req1_ready), 32'(1'b0));
        chk({tag, "_start"}, 32'(tx_start), 32'(1'b0));
        chk({tag, "_data"}, 32'(tx_data), 32'(8'h00));
        chk({tag, "_grant"}, 32'(grant), 32'(2'b00));
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(16'h0000));
        chk({tag, "_err"}, 32'(err_timeout), 32'(1'b0));
    endtask

    initial begin
        int starts;
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_data  = 8'h00;
        req1_data  = 8'h00;
        hold_busy  = 1'b0;
        model_kill = 1'b0;
        done_delay = 20;

        vecs[0] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 2'b10};
        vecs[1] = '{1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 2'b01};
        vecs[2] = '{1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b0, 8'h77, 2'b01};
        vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 2'b10};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b1, 8'h99, 2'b10};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 2'b00};
        order_exp[0] = 8'h11;
        order_exp[1] = 8'h22;
        order_exp[2] = 8'h11;
        order_exp[3] = 8'h22;

        // Reset values, with a valid request held to show ready is forced low
        #3;
        check_reset_outputs("por");
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single request from requester 0
        tick();
        req0_valid = 1'b1;
        req0_data  = 8'hA5;
        #1;
        chk("a5_rdy0", 32'(req0_ready), 32'(1'b1));
        chk("a5_rdy1", 32'(req1_ready), 32'(1'b0));
        tick();
        chk("a5_start", 32'(tx_start), 32'(1'b1));
        chk("a5_data", 32'(tx_data), 32'(8'hA5));
        chk("a5_grant", 32'(grant), 32'(2'b01));
        chk("a5_rdy0_busy", 32'(req0_ready), 32'(1'b0));
        req0_valid = 1'b0;
        tick();
        chk("a5_start_low", 32'(tx_start), 32'(1'b0));
        repeat (19) tick();
        chk("a5_fcnt_before", 32'(frame_cnt), 32'(16'd0));
        tick();
        chk("a5_fcnt", 32'(frame_cnt), 32'(16'd1));
        chk("a5_grant_gap", 32'(grant), 32'(2'b01));
        repeat (3) tick();
        chk("a5_grant_gap_end", 32'(grant), 32'(2'b01));
        tick();
        chk("a5_grant_idle", 32'(grant), 32'(2'b00));
        chk("a5_data_held", 32'(tx_data), 32'(8'hA5));

        // Arbitration table
        for (int i = 0; i < 6; i++) begin
            tick();
            req0_valid = vecs[i].v0;
            req0_data  = vecs[i].d0;
            req1_valid = vecs[i].v1;
            req1_data  = vecs[i].d1;
            #1;
            chk($sformatf("vec%0d_rdy0", i), 32'(req0_ready), 32'(vecs[i].rdy0));
            chk($sformatf("vec%0d_rdy1", i), 32'(req1_ready), 32'(vecs[i].rdy1));
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vecs[i].gnt != 2'b00));
            chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].data));
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].gnt));
            wait_idle($sformatf("vec%0d_idle", i), 100);
        end
        chk("table_fcnt", 32'(frame_cnt), 32'(16'd6));

        // Transmitter busy in IDLE: no ready, and a dropped valid transfers nothing
        tick();
        hold_busy  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'hC3;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy_rdy0_%0d", k), 32'(req0_ready), 32'(1'b0));
            tick();
        end
        req0_valid = 1'b0;
        hold_busy  = 1'b0;
        tick();
        chk("drop_start", 32'(tx_start), 32'(1'b0));
        chk("drop_grant", 32'(grant), 32'(2'b00));
        chk("drop_data", 32'(tx_data), 32'(8'h99));

        // Both requesters held valid for four frames
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        req1_valid = 1'b1;
        req1_data  = 8'h22;
        for (int f = 0; f < 4; f++) begin
            wait_start($sformatf("rr_start%0d", f), 100);
            chk($sformatf("rr_order%0d", f), 32'(tx_data), 32'(order_exp[f]));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("rr_idle", 100);
        chk("rr_fcnt", 32'(frame_cnt), 32'(16'd10));

        // No tx_done: timeout after TMO cycles, then service continues
        done_delay = 0;
        tick();
        req0_valid = 1'b1;
        req0_data  = 8'hE1;
        tick();
        chk("to_start", 32'(tx_start), 32'(1'b1));
        req0_valid = 1'b0;
        repeat (TMO - 1) tick();
        chk("to_err_early", 32'(err_timeout), 32'(1'b0));
        tick();
        chk("to_err", 32'(err_timeout), 32'(1'b1));
        chk("to_fcnt", 32'(frame_cnt), 32'(16'd10));
        chk("to_grant", 32'(grant), 32'(2'b01));
        model_kill = 1'b1;
        tick();
        model_kill = 1'b0;
        done_delay = 20;
        wait_idle("to_idle", 100);
        req1_valid = 1'b1;
        req1_data  = 8'h42;
        #1;
        chk("to_next_rdy1", 32'(req1_ready), 32'(1'b1));
        tick();
        req1_valid = 1'b0;
        chk("to_next_data", 32'(tx_data), 32'(8'h42));
        chk("to_next_grant", 32'(grant), 32'(2'b10));
        wait_idle("to_next_idle", 100);
        chk("to_next_fcnt", 32'(frame_cnt), 32'(16'd11));
        chk("to_sticky", 32'(err_timeout), 32'(1'b1));

        // tx_done in the same cycle as the timeout
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        done_delay = TMO - 1;
        tick();
        req0_valid = 1'b1;
        req0_data  = 8'h6B;
        tick();
        chk("co_start", 32'(tx_start), 32'(1'b1));
        req0_valid = 1'b0;
        repeat (TMO) tick();
        chk("co_err", 32'(err_timeout), 32'(1'b0));
        chk("co_fcnt", 32'(frame_cnt), 32'(16'd1));
        wait_idle("co_idle", 100);

        // Reset during WAIT_DONE
        done_delay = 20;
        req0_valid = 1'b1;
        req0_data  = 8'hD4;
        tick();
        chk("mr_start", 32'(tx_start), 32'(1'b1));
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mr");
        req0_valid = 1'b0;
        tick();
        rst_n  = 1'b1;
        starts = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (tx_start === 1'b1) starts++;
        end
        chk("mr_no_start", 32'(starts), 32'(0));
        chk("mr_grant", 32'(grant), 32'(2'b00));

        // frame_cnt wrap
        force dut.frame_cnt_r = 16'hFFFF;
        tick();
        release dut.frame_cnt_r;
        #1;
        chk("wrap_pre", 32'(frame_cnt), 32'(16'hFFFF));
        req1_valid = 1'b1;
        req1_data  = 8'h5E;
        tick();
        req1_valid = 1'b0;
        chk("wrap_start", 32'(tx_start), 32'(1'b1));
        wait_idle("wrap_idle", 100);
        chk("wrap_fcnt", 32'(frame_cnt), 32'(16'h0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 868, which sets the idle cycles inserted after each frame (one bit time at 100 MHz / 115200).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 20000, which sets the maximum cycles from tx_start to tx_done.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N offers a byte.
REQ-006 The block SHALL have ports req0_data and req1_data, input, 8 bits each: the offered byte, held stable while valid.
REQ-007 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the byte is accepted in a cycle where valid and ready are both high.
REQ-008 The block SHALL have port tx_start, output, 1 bit: one-cycle pulse that launches a frame on the transmitter.
REQ-009 The block SHALL have port tx_data, output, 8 bits: the byte to transmit, valid from tx_start until the next accept.
REQ-010 The block SHALL have port tx_busy, input, 1 bit: the transmitter is mid-frame.
REQ-011 The block SHALL have port tx_done, input, 1 bit: one-cycle pulse at the end of the stop bit.
REQ-012 The block SHALL have port grant, output, 2 bits: one-hot owner of the current frame, 2'b00 when none.
REQ-013 The block SHALL have port frame_cnt, output, 16 bits: count of completed frames.
REQ-014 The block SHALL have port err_timeout, output, 1 bit: sticky flag set when tx_done is missed.

Function
REQ-015 The block SHALL implement the FSM states IDLE, START, WAIT_DONE and GAP.
REQ-016 In IDLE with tx_busy=0, the block SHALL select a winner combinationally among the valid requesters and assert that requester's ready in the same cycle; the other ready stays 0.
REQ-017 Arbitration SHALL be round-robin: when both requesters are valid, the one not served last wins; the last-served pointer resets to requester 1, so requester 0 wins the first tie.
REQ-018 When only one requester is valid, that requester SHALL win regardless of the pointer.
REQ-019 On an accept, the block SHALL latch the data into tx_data, set grant to the winner, update the pointer, and go to START.
REQ-020 If valid drops before an accept, the block SHALL not transfer data and SHALL not change state.
REQ-021 In IDLE with tx_busy=1, no ready SHALL be asserted and the block SHALL stay in IDLE.
REQ-022 START SHALL last exactly 1 cycle with tx_start=1, then go to WAIT_DONE; tx_start SHALL be 0 in every other state.
REQ-023 The accept-to-tx_start latency SHALL be 1 cycle.
REQ-024 In WAIT_DONE, a cycle counter SHALL run from 0; on tx_done the block SHALL increment frame_cnt and go to GAP.
REQ-025 If the counter reaches TIMEOUT_CYCLES without tx_done, the block SHALL set err_timeout=1, leave frame_cnt unchanged, and go to GAP.
REQ-026 If tx_done and the timeout occur in the same cycle, tx_done SHALL win and err_timeout SHALL not be set.
REQ-027 frame_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-028 err_timeout SHALL stay at 1 until reset.
REQ-029 GAP SHALL last exactly GAP_CYCLES cycles, then go to IDLE with grant=2'b00; when GAP_CYCLES=0, the block SHALL go from WAIT_DONE directly to IDLE.
REQ-030 A tx_done pulse outside WAIT_DONE SHALL be ignored.
REQ-031 No ready SHALL be asserted outside IDLE, so at most one byte is in flight.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force: state IDLE; req0_ready and req1_ready to 0; tx_start 0; tx_data 8'h00; grant 2'b00; frame_cnt 0; err_timeout 0; round-robin pointer to requester 1; all counters 0.
REQ-033 A reset asserted mid-frame SHALL abandon the frame with no tx_start glitch, and the first cycle after release SHALL be IDLE.

Verification
REQ-034 The bench SHALL drive req0_valid with data 8'hA5 and a transmitter model giving tx_done 20 cycles after tx_start, and SHALL check: req0_ready for 1 cycle, tx_start 1 cycle later with tx_data=8'hA5, grant=2'b01, frame_cnt=1, then IDLE after GAP_CYCLES.
REQ-035 The bench SHALL hold both requesters valid (8'h11 / 8'h22) for 4 frames and SHALL check the transmitted order 11, 22, 11, 22.
REQ-036 The bench SHALL give no tx_done with TIMEOUT_CYCLES=50 and SHALL check: err_timeout rises 50 cycles after tx_start, frame_cnt is unchanged, and the next request is still served.
REQ-037 The bench SHALL pulse tx_done in the same cycle as the timeout and SHALL check err_timeout=0 and frame_cnt incremented.
REQ-038 The bench SHALL assert rst_n=0 during WAIT_DONE and SHALL check that all outputs take their reset values immediately and no tx_start occurs after release without a new request.
REQ-039 The bench SHALL preload frame_cnt to 16'hFFFF and complete 1 frame, and SHALL check frame_cnt=16'h0000.
